pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen.sv | 105 ++++++++++
 tb/tb_pc_gen.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Program counter generator: sequential increment, stall hold, buffered
// redirects, trap entry, misaligned-target rejection and post-load bubbles.
module pc_gen #(
    parameter int unsigned XLEN       = 32,
    parameter logic [31:0] RESET_VEC  = 32'h0000_0000,
    parameter int unsigned INC        = 4,
    parameter int unsigned ALIGN_BITS = 2,
    parameter int unsigned FLUSH_CYC  = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_stall,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    input  logic            i_trap,
    input  logic [XLEN-1:0] i_trap_vec,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pc_plus,
    output logic            o_valid,
    output logic            o_misalign,
    output logic            o_redirect_pend
);

    localparam int unsigned CNT_W = 3;
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);
    localparam logic [XLEN-1:0] INC_V      = XLEN'(INC);
    localparam logic [XLEN-1:0] RST_PC     = XLEN'(RESET_VEC);
    localparam logic [CNT_W-1:0] FLUSH_V   = CNT_W'(FLUSH_CYC);

    logic [XLEN-1:0]  pc_q, pc_n;
    logic [XLEN-1:0]  pend_pc_q, pend_pc_n;
    logic             pend_q, pend_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             valid_q, valid_n;
    logic             mis_q, mis_n;
    logic             misaligned;
    logic             redir_ok;
    logic             load;

    // Next-state selection in priority order: trap, redirect, pending, stall, increment.
    always_comb begin
        pc_n      = pc_q;
        pend_pc_n = pend_pc_q;
        pend_n    = pend_q;
        cnt_n     = cnt_q;
        load      = 1'b0;
        misaligned = |(i_redirect_pc & ALIGN_MASK);
        redir_ok   = i_redirect & ~misaligned;
        mis_n      = i_redirect & misaligned;

        if (i_trap) begin
            pc_n   = i_trap_vec;
            pend_n = 1'b0;
            load   = 1'b1;
        end else if (redir_ok && !i_stall) begin
            pc_n   = i_redirect_pc;
            pend_n = 1'b0;
            load   = 1'b1;
        end else if (redir_ok && i_stall) begin
            pend_n    = 1'b1;
            pend_pc_n = i_redirect_pc;
        end else if (pend_q && !i_stall) begin
            pc_n   = pend_pc_q;
            pend_n = 1'b0;
            load   = 1'b1;
        end else if (!i_stall) begin
            pc_n = pc_q + INC_V;
        end

        if (load) begin
            cnt_n = FLUSH_V;
        end else if (!i_stall && cnt_q != '0) begin
            cnt_n = cnt_q - CNT_W'(1);
        end

        valid_n = (cnt_n == '0);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            pc_q      <= RST_PC;
            pend_pc_q <= '0;
            pend_q    <= 1'b0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            mis_q     <= 1'b0;
        end else begin
            pc_q      <= pc_n;
            pend_pc_q <= pend_pc_n;
            pend_q    <= pend_n;
            cnt_q     <= cnt_n;
            valid_q   <= valid_n;
            mis_q     <= mis_n;
        end
    end

    // Output mapping; o_pc_plus is the only combinational output.
    assign o_pc            = pc_q;
    assign o_pc_plus       = pc_q + INC_V;
    assign o_valid         = valid_q;
    assign o_misalign      = mis_q;
    assign o_redirect_pend = pend_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: default instance, FLUSH_CYC=0 instance, XLEN=8 instance.
module tb_pc_gen;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        trap;
    logic [31:0] trap_vec;

    logic [31:0] pc, pc_plus;
    logic        valid, misalign, pend;

    logic [31:0] pc0, pc_plus0;
    logic        valid0, misalign0, pend0;

    logic        r8;
    logic [7:0]  rpc8;
    logic [7:0]  pc8, pc_plus8;
    logic        valid8, misalign8, pend8;

    int total = 0;
    int bad   = 0;

    pc_gen dut (
        .i_clk(clk), .i_rst(rst), .i_stall(stall),
        .i_redirect(redirect), .i_redirect_pc(redirect_pc),
        .i_trap(trap), .i_trap_vec(trap_vec),
        .o_pc(pc), .o_pc_plus(pc_plus), .o_valid(valid),
        .o_misalign(misalign), .o_redirect_pend(pend)
    );

    pc_gen #(.FLUSH_CYC(0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_stall(stall),
        .i_redirect(redirect), .i_redirect_pc(redirect_pc),
        .i_trap(trap), .i_trap_vec(trap_vec),
        .o_pc(pc0), .o_pc_plus(pc_plus0), .o_valid(valid0),
        .o_misalign(misalign0), .o_redirect_pend(pend0)
    );

    pc_gen #(.XLEN(8)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_stall(1'b0),
        .i_redirect(r8), .i_redirect_pc(rpc8),
        .i_trap(1'b0), .i_trap_vec(8'h00),
        .o_pc(pc8), .o_pc_plus(pc_plus8), .o_valid(valid8),
        .o_misalign(misalign8), .o_redirect_pend(pend8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        trap = 1'b0; trap_vec = '0; r8 = 1'b0; rpc8 = '0;

        // Reset state
        step(); step();
        chk("rst_pc", pc, 32'h0);
        chk("rst_pend", 32'(pend), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_mis", 32'(misalign), 32'h0);

        // Release: 4, 8, 12, 16 with valid from the first cycle
        rst = 1'b1;
        step();
        chk("seq1_pc", pc, 32'h4);
        chk("seq1_valid", 32'(valid), 32'h1);
        chk("seq1_plus", pc_plus, 32'h8);
        step(); chk("seq2_pc", pc, 32'h8);
        step(); chk("seq3_pc", pc, 32'hC);
        step(); chk("seq4_pc", pc, 32'h10);

        // Redirect behind a stall, overwritten while still stalled
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
        step();
        chk("pend1_pc", pc, 32'h10);
        chk("pend1_flag", 32'(pend), 32'h1);
        redirect_pc = 32'h300;
        step();
        chk("pend2_pc", pc, 32'h10);
        chk("pend2_flag", 32'(pend), 32'h1);
        stall = 1'b0; redirect = 1'b0;
        step();
        chk("rel_pc", pc, 32'h300);
        chk("rel_valid", 32'(valid), 32'h0);
        chk("rel_pend", 32'(pend), 32'h0);
        chk("nf_valid", 32'(valid0), 32'h1);
        chk("nf_pc", pc0, 32'h300);
        step();
        chk("rel2_pc", pc, 32'h304);
        chk("rel2_valid", 32'(valid), 32'h1);

        // New redirect at stall release beats the pending target
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h300;
        step();
        chk("ovr_hold", pc, 32'h304);
        stall = 1'b0; redirect_pc = 32'h400;
        step();
        chk("ovr_pc", pc, 32'h400);
        chk("ovr_pend", 32'(pend), 32'h0);
        chk("ovr_valid", 32'(valid), 32'h0);
        redirect = 1'b0;
        step();
        chk("ovr2_pc", pc, 32'h404);
        chk("ovr2_valid", 32'(valid), 32'h1);

        // Misaligned redirect is rejected and pulses o_misalign
        redirect = 1'b1; redirect_pc = 32'h102;
        step();
        chk("mis_pc", pc, 32'h408);
        chk("mis_flag", 32'(misalign), 32'h1);
        chk("mis_valid", 32'(valid), 32'h1);
        redirect = 1'b0;
        step();
        chk("mis2_pc", pc, 32'h40C);
        chk("mis2_flag", 32'(misalign), 32'h0);

        // Trap while stalled with a pending redirect
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h500;
        step();
        chk("tp_pend", 32'(pend), 32'h1);
        redirect = 1'b0; trap = 1'b1; trap_vec = 32'h800;
        step();
        chk("trap_pc", pc, 32'h800);
        chk("trap_pend", 32'(pend), 32'h0);
        chk("trap_valid", 32'(valid), 32'h0);
        trap = 1'b0;
        step();
        chk("trap_hold_pc", pc, 32'h800);
        chk("trap_frz_valid", 32'(valid), 32'h0);
        stall = 1'b0;
        step();
        chk("trap_adv_pc", pc, 32'h804);
        chk("trap_adv_valid", 32'(valid), 32'h1);

        // Misaligned trap vector is still taken
        trap = 1'b1; trap_vec = 32'h902;
        step();
        chk("mtrap_pc", pc, 32'h902);
        chk("mtrap_mis", 32'(misalign), 32'h0);
        trap = 1'b0;
        step();
        chk("mtrap2_pc", pc, 32'h906);

        // Reset while pending, with trap/redirect asserted, discards everything
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h600;
        step();
        chk("rp_pend", 32'(pend), 32'h1);
        rst = 1'b0; trap = 1'b1; trap_vec = 32'h800;
        step();
        chk("rp_pc", pc, 32'h0);
        chk("rp_pend0", 32'(pend), 32'h0);
        chk("rp_valid", 32'(valid), 32'h0);
        rst = 1'b1; trap = 1'b0; redirect = 1'b0; stall = 1'b0;
        step();
        chk("rp_rel_pc", pc, 32'h4);
        chk("rp_rel_pend", 32'(pend), 32'h0);
        chk("rp_rel_valid", 32'(valid), 32'h1);

        // XLEN=8 wrap from 0xFC
        r8 = 1'b1; rpc8 = 8'hFC;
        step();
        chk("x8_pc", 32'(pc8), 32'hFC);
        chk("x8_plus", 32'(pc_plus8), 32'h00);
        r8 = 1'b0;
        step();
        chk("x8_wrap", 32'(pc8), 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
